// File: rtl/chan_proc_p.sv
// chan_proc_p -- one ADC channel processor.
//
// Purpose:
//   Tracks a running pedestal, pedestal-corrects incoming samples into a
//   circular sample buffer, and on master or self triggers copies a window
//   of that buffer into a 16-bit output FIFO as framed blocks. Blocks are
//   committed (made visible) only when complete; master blocks are also
//   dropped when no sample exceeds the zero-suppression threshold.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   din_vld, din        ADC sample strobe and raw sample
//   num                 channel number placed in block headers
//   cped                common pedestal added back after subtraction
//   zthr, sthr          zero-suppression / self-trigger thresholds
//   prescale            self-trigger prescale
//   winbeg, swinbeg     master / self window offset before the trigger
//   winlen              window length in samples
//   trigger             master trigger word, bit 15 is the strobe
//   tmask, stmask       master / self trigger masks
//   raw                 test mode: no correction, no zero suppression
//   ped                 current pedestal
//   dout, req, ack      show-ahead FIFO head word, non-empty flag, pop
//   fifo_full           not enough FIFO space for another block
//   mt_lost             saturating count of dropped master triggers
module chan_proc_p #(
  parameter int DW    = 12,
  parameter int AW    = 10,
  parameter int FAW   = 11,
  parameter int PBITS = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          din_vld,
  input  logic [DW-1:0] din,
  input  logic [5:0]    num,
  input  logic [DW-1:0] cped,
  input  logic [DW-1:0] zthr,
  input  logic [DW-1:0] sthr,
  input  logic [15:0]   prescale,
  input  logic [AW-1:0] winbeg,
  input  logic [AW-1:0] swinbeg,
  input  logic [7:0]    winlen,
  input  logic [15:0]   trigger,
  input  logic          tmask,
  input  logic          stmask,
  input  logic          raw,
  output logic [DW-1:0] ped,
  output logic [15:0]   dout,
  output logic          req,
  input  logic          ack,
  output logic          fifo_full,
  output logic [15:0]   mt_lost
);

  typedef enum logic [2:0] {IDLE, STCOPY, MTHDR, MTNUM, MTCOPY} state_t;

  localparam int FD = 1 << FAW;
  localparam int CW = (FAW + 2 > 10) ? FAW + 2 : 10;
  localparam logic [AW-1:0] A1 = AW'(1);
  localparam logic [FAW:0]  P1 = (FAW+1)'(1);

  logic [DW-1:0] buf_mem [0:(1<<AW)-1];
  logic [15:0]   fifo_mem [0:FD-1];
  logic [DW-1:0] buf_rdata;

  logic [DW+PBITS-1:0] ped_sum_q, ped_sum_d;
  logic [PBITS:0]      ped_cnt_q, ped_cnt_d;
  logic [DW-1:0]       ped_q, ped_d;
  logic [AW-1:0]       waddr_q, waddr_d, raddr_q, raddr_d;
  logic [AW-1:0]       saddr_q, saddr_d, maddr_q, maddr_d;
  logic                armed_q, armed_d, st_pend_q, st_pend_d, mt_pend_q, mt_pend_d;
  logic [15:0]         presc_cnt_q, presc_cnt_d, mt_word_q, mt_word_d, mt_lost_q, mt_lost_d;
  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                hit_q, hit_d;
  logic [FAW:0]        wptr_q, wptr_d, cptr_q, cptr_d, rptr_q, rptr_d, blk_start_q, blk_start_d;
  logic                fifo_full_q, fifo_full_d, req_q, req_d;
  logic [15:0]         dout_q;

  logic          st_fire, st_take, mt_take, fifo_we, sample_hit;
  logic [15:0]   fifo_wdata;
  logic [FAW:0]  used_d;
  logic [CW-1:0] free_d, need_d;

  // Pedestal correction done at DW+2 bits so both underflow and overflow
  // are visible and can be clamped instead of wrapping.
  logic [DW+1:0] pdiff;
  logic [DW-1:0] pdata;
  logic [DW:0]   sthr_lvl, zthr_lvl;
  assign pdiff    = {2'b00, din} + {2'b00, cped} - {2'b00, ped_q};
  assign pdata    = raw ? din : (pdiff[DW+1] ? '0 : (pdiff[DW] ? '1 : pdiff[DW-1:0]));
  assign sthr_lvl = {1'b0, sthr} + {1'b0, cped};
  assign zthr_lvl = {1'b0, zthr} + {1'b0, cped};

  // Sample buffer: write at waddr, registered read at raddr.
  always_ff @(posedge clk) begin
    if (din_vld) buf_mem[waddr_q] <= pdata;
    buf_rdata <= buf_mem[raddr_q];
  end

  always_ff @(posedge clk) begin
    if (fifo_we) fifo_mem[wptr_q[FAW-1:0]] <= fifo_wdata;
  end

  always_comb begin
    ped_sum_d = ped_sum_q; ped_cnt_d = ped_cnt_q; ped_d = ped_q; waddr_d = waddr_q;
    armed_d = armed_q; presc_cnt_d = presc_cnt_q; st_fire = 1'b0;
    state_d = state_q; raddr_d = raddr_q; cnt_d = cnt_q; hit_d = hit_q;
    wptr_d = wptr_q; cptr_d = cptr_q; blk_start_d = blk_start_q;
    fifo_we = 1'b0; fifo_wdata = '0; st_take = 1'b0; mt_take = 1'b0; sample_hit = 1'b0;

    // Front end: pedestal, buffer address, self-trigger arming/prescale.
    if (din_vld) begin
      waddr_d = waddr_q + A1;
      if (ped_cnt_q[PBITS]) begin
        // A full 2^PBITS sum is held: publish it, current sample starts the next.
        ped_d     = DW'(ped_sum_q >> PBITS);
        ped_sum_d = (DW+PBITS)'(din);
        ped_cnt_d = (PBITS+1)'(1);
      end else begin
        ped_sum_d = ped_sum_q + (DW+PBITS)'(din);
        ped_cnt_d = ped_cnt_q + (PBITS+1)'(1);
      end
      if (!armed_q && ({1'b0, pdata} > sthr_lvl)) begin
        armed_d = 1'b1;
        if (presc_cnt_q >= prescale) begin
          presc_cnt_d = '0;
          st_fire     = !stmask && !raw;
        end else begin
          presc_cnt_d = presc_cnt_q + 16'd1;
        end
      end else if (armed_q && ({1'b0, pdata} < sthr_lvl)) begin
        armed_d = 1'b0;
      end
    end

    // Block writer. Words go in at wptr; cptr moves only on commit, and a
    // discard rewinds wptr to the block start.
    case (state_q)
      IDLE: begin
        if (!fifo_full_q && mt_pend_q) begin
          state_d = MTHDR; mt_take = 1'b1;
          raddr_d = maddr_q - winbeg; blk_start_d = wptr_q;
        end else if (!fifo_full_q && st_pend_q) begin
          state_d = STCOPY; st_take = 1'b1; cnt_d = '0;
          raddr_d = saddr_q - swinbeg; blk_start_d = wptr_q;
        end
      end
      STCOPY: begin
        if (mt_pend_q) begin
          wptr_d  = blk_start_q;   // master trigger preempts the self block
          state_d = IDLE;
        end else begin
          fifo_we    = 1'b1;
          fifo_wdata = (cnt_q == 8'd0) ? {2'b10, num, winlen} : {{(16-DW){1'b0}}, buf_rdata};
          wptr_d     = wptr_q + P1;
          raddr_d    = raddr_q + A1;
          if (cnt_q == winlen) begin
            cptr_d  = wptr_q + P1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      MTHDR: begin
        // raddr is held here so the first sample read lands in MTNUM.
        fifo_we = 1'b1; fifo_wdata = {2'b11, num, winlen};
        wptr_d = wptr_q + P1; hit_d = 1'b0; state_d = MTNUM;
      end
      MTNUM: begin
        fifo_we = 1'b1; fifo_wdata = mt_word_q;
        wptr_d = wptr_q + P1; raddr_d = raddr_q + A1; cnt_d = 8'd1;
        if (winlen == 8'd0) begin
          if (raw) cptr_d = wptr_q + P1;
          else     wptr_d = blk_start_q;
          state_d = IDLE;
        end else begin
          state_d = MTCOPY;
        end
      end
      MTCOPY: begin
        fifo_we    = 1'b1;
        fifo_wdata = {{(16-DW){1'b0}}, buf_rdata};
        wptr_d     = wptr_q + P1;
        raddr_d    = raddr_q + A1;
        sample_hit = {1'b0, buf_rdata} > zthr_lvl;
        hit_d      = hit_q | sample_hit;
        if (cnt_q == winlen) begin
          if (raw || hit_q || sample_hit) cptr_d = wptr_q + P1;
          else                            wptr_d = blk_start_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Pending slots; a slot freed this cycle may be refilled this cycle.
    mt_pend_d = mt_pend_q & ~mt_take; mt_word_d = mt_word_q; maddr_d = maddr_q; mt_lost_d = mt_lost_q;
    if (trigger[15] && !tmask) begin
      if (mt_pend_d) begin
        if (mt_lost_q != 16'hFFFF) mt_lost_d = mt_lost_q + 16'd1;
      end else begin
        mt_pend_d = 1'b1; mt_word_d = trigger; maddr_d = waddr_q;
      end
    end
    st_pend_d = st_pend_q & ~st_take; saddr_d = saddr_q;
    if (st_fire && !st_pend_d) begin
      st_pend_d = 1'b1; saddr_d = waddr_q;
    end

    // Read side. req looks at the registered commit pointer, so a word is
    // only announced once its RAM write has landed and dout can show it.
    rptr_d = rptr_q;
    if (req_q && ack) rptr_d = rptr_q + P1;
    req_d       = (cptr_q != rptr_d);
    used_d      = wptr_d - rptr_d;
    free_d      = CW'(FD) - CW'(used_d);
    need_d      = CW'(winlen) + CW'(2);
    fifo_full_d = free_d < need_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ped_sum_q <= '0; ped_cnt_q <= '0; ped_q <= '0; waddr_q <= '0; raddr_q <= '0;
      saddr_q <= '0; maddr_q <= '0; armed_q <= 1'b0; st_pend_q <= 1'b0; mt_pend_q <= 1'b0;
      presc_cnt_q <= '0; mt_word_q <= '0; mt_lost_q <= '0; state_q <= IDLE;
      cnt_q <= '0; hit_q <= 1'b0; wptr_q <= '0; cptr_q <= '0; rptr_q <= '0;
      blk_start_q <= '0; fifo_full_q <= 1'b0; req_q <= 1'b0; dout_q <= '0;
    end else begin
      ped_sum_q <= ped_sum_d; ped_cnt_q <= ped_cnt_d; ped_q <= ped_d; waddr_q <= waddr_d;
      raddr_q <= raddr_d; saddr_q <= saddr_d; maddr_q <= maddr_d; armed_q <= armed_d;
      st_pend_q <= st_pend_d; mt_pend_q <= mt_pend_d; presc_cnt_q <= presc_cnt_d;
      mt_word_q <= mt_word_d; mt_lost_q <= mt_lost_d; state_q <= state_d;
      cnt_q <= cnt_d; hit_q <= hit_d; wptr_q <= wptr_d; cptr_q <= cptr_d; rptr_q <= rptr_d;
      blk_start_q <= blk_start_d; fifo_full_q <= fifo_full_d; req_q <= req_d;
      dout_q <= fifo_mem[rptr_d[FAW-1:0]];
    end
  end

  assign ped       = ped_q;
  assign dout      = dout_q;
  assign req       = req_q;
  assign fifo_full = fifo_full_q;
  assign mt_lost   = mt_lost_q;

endmodule

// File: tb/tb_chan_proc_p.sv
`timescale 1ns/1ps
module tb_chan_proc_p;
  localparam int DW = 12, AW = 10, FAW = 5, PBITS = 4;

  logic          clk = 1'b0, rst = 1'b1, din_vld = 1'b0;
  logic [DW-1:0] din = '0, cped = '0, zthr = '0, sthr = '0;
  logic [5:0]    num = 6'd5;
  logic [15:0]   prescale = '0, trigger = '0;
  logic [AW-1:0] winbeg = '0, swinbeg = '0;
  logic [7:0]    winlen = '0;
  logic          tmask = 1'b0, stmask = 1'b1, raw = 1'b0, ack = 1'b1;
  logic [DW-1:0] ped;
  logic [15:0]   dout, mt_lost;
  logic          req, fifo_full;

  chan_proc_p #(.DW(DW), .AW(AW), .FAW(FAW), .PBITS(PBITS)) dut (
    .clk(clk), .rst(rst), .din_vld(din_vld), .din(din), .num(num), .cped(cped),
    .zthr(zthr), .sthr(sthr), .prescale(prescale), .winbeg(winbeg), .swinbeg(swinbeg),
    .winlen(winlen), .trigger(trigger), .tmask(tmask), .stmask(stmask), .raw(raw),
    .ped(ped), .dout(dout), .req(req), .ack(ack), .fifo_full(fifo_full), .mt_lost(mt_lost)
  );

  always #5 clk = ~clk;

  int n_total = 0, n_pass = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, want);
  endtask

  // Monitor: every word popped by the DUT is compared with the scoreboard.
  always @(negedge clk) begin
    logic [15:0] e;
    if (!rst && req && ack) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_word: got %0h, required no word", dout);
      end else begin
        e = exp_q.pop_front();
        check("fifo_word", 32'(dout), 32'(e));
        $display("word %04h expected %04h", dout, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic samp(input logic [DW-1:0] d);
    din = d; din_vld = 1'b1; tick(); din_vld = 1'b0;
  endtask

  task automatic mtrig(input logic [15:0] w);
    trigger = w; tick(); trigger = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; repeat (2) tick(); rst = 1'b0; tick();
    check("req_after_reset", 32'(req), 32'd0);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    repeat (5) tick();
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else begin
      $display("FAIL drain_timeout: %0d words still pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen;
    repeat (3) tick();
    check("rst_ped", 32'(ped), 32'd0);
    check("rst_req", 32'(req), 32'd0);
    check("rst_fifo_full", 32'(fifo_full), 32'd0);
    check("rst_mt_lost", 32'(mt_lost), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    rst = 1'b0; tick();

    // Pedestal learning, correction and clamping.
    do_reset();
    stmask = 1'b1; winlen = 8'd4; winbeg = 10'd4; zthr = '0; cped = '0;
    repeat (20) samp(12'd100);
    check("ped_avg", 32'(ped), 32'd100);
    cped = 12'd50;
    exp_q.push_back(16'hC504); exp_q.push_back(16'h8055);
    exp_q.push_back(16'd51); exp_q.push_back(16'd50); exp_q.push_back(16'd50); exp_q.push_back(16'd0);
    samp(12'd101); samp(12'd100); samp(12'd100); samp(12'd20);
    mtrig(16'h8055);
    drain(100);

    // Self trigger with prescale 2: only the third pulse makes a block.
    do_reset();
    cped = '0; sthr = 12'd200; prescale = 16'd2; winlen = 8'd4; swinbeg = 10'd3; stmask = 1'b0;
    exp_q.push_back(16'h8504); exp_q.push_back(16'd10); exp_q.push_back(16'd300);
    exp_q.push_back(16'd10); exp_q.push_back(16'd300);
    samp(12'd10); samp(12'd10); samp(12'd10); samp(12'd10);
    samp(12'd300); samp(12'd10); samp(12'd300); samp(12'd10); samp(12'd300);
    drain(100);
    stmask = 1'b1;

    // Master block kept by one sample over threshold, then a suppressed one.
    do_reset();
    zthr = 12'd100; winlen = 8'd8; winbeg = 10'd8;
    exp_q.push_back(16'hC508); exp_q.push_back(16'h8123);
    foreach (exp_q[i]) ; // no-op keeps ordering explicit
    exp_q.push_back(16'd5); exp_q.push_back(16'd6); exp_q.push_back(16'd7); exp_q.push_back(16'd8);
    exp_q.push_back(16'd150); exp_q.push_back(16'd9); exp_q.push_back(16'd10); exp_q.push_back(16'd11);
    samp(12'd5); samp(12'd6); samp(12'd7); samp(12'd8);
    samp(12'd150); samp(12'd9); samp(12'd10); samp(12'd11);
    mtrig(16'h8123);
    drain(100);
    repeat (8) samp(12'd50);
    mtrig(16'h8123);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin tick(); if (req) seen = 1'b1; end
    check("suppressed_block_req", 32'(seen), 32'd0);

    // Reset in the middle of a raw master block discards it.
    raw = 1'b1;
    mtrig(16'h8001);
    repeat (4) tick();
    do_reset();
    repeat (20) tick();
    check("midblock_reset_req", 32'(req), 32'd0);
    raw = 1'b0;

    // Master trigger during a self copy aborts it.
    do_reset();
    sthr = 12'd200; prescale = '0; stmask = 1'b0; zthr = 12'd100;
    winlen = 8'd6; swinbeg = 10'd6; winbeg = 10'd6;
    exp_q.push_back(16'hC506); exp_q.push_back(16'h8ABC);
    exp_q.push_back(16'd2); exp_q.push_back(16'd3); exp_q.push_back(16'd4);
    exp_q.push_back(16'd5); exp_q.push_back(16'd6); exp_q.push_back(16'd300);
    samp(12'd1); samp(12'd2); samp(12'd3); samp(12'd4); samp(12'd5); samp(12'd6); samp(12'd300);
    repeat (2) tick();
    mtrig(16'h8ABC);
    drain(100);

    // Three triggers during a busy master block: one queued, two lost.
    stmask = 1'b1; zthr = 12'hFFF; winlen = 8'd30; winbeg = 10'd30;
    mtrig(16'h8001);
    repeat (5) tick();
    mtrig(16'h8002); tick(); mtrig(16'h8003); tick(); mtrig(16'h8004);
    check("mt_lost_two", 32'(mt_lost), 32'd2);
    repeat (100) tick();
    check("mt_lost_stable", 32'(mt_lost), 32'd2);
    check("discarded_blocks_req", 32'(req), 32'd0);

    // FIFO fill to full, blocked start, then continuous drain across wrap.
    do_reset();
    raw = 1'b1; winlen = 8'd8; winbeg = 10'd8; zthr = '0; ack = 1'b0;
    for (int b = 0; b < 4; b++) begin
      exp_q.push_back(16'hC508); exp_q.push_back(16'h8000 | 16'(b));
      for (int i = 0; i < 8; i++) exp_q.push_back(16'(b * 16 + i + 1));
      for (int i = 0; i < 8; i++) samp(DW'(b * 16 + i + 1));
      mtrig(16'h8000 | 16'(b));
      repeat (15) tick();
      if (b < 2)       check("fifo_full_low", 32'(fifo_full), 32'd0);
      else if (b == 2) check("fifo_full_high", 32'(fifo_full), 32'd1);
      else begin
        check("fifo_full_blocks", 32'(fifo_full), 32'd1);
        check("req_full", 32'(req), 32'd1);
      end
    end
    ack = 1'b1;
    drain(300);
    check("fifo_full_after_drain", 32'(fifo_full), 32'd0);
    check("req_after_drain", 32'(req), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/chan_proc_p.md
CHAN_PROC_P -- requirements
Module: chan_proc_p

Interface
REQ-001 SHALL have parameter DW, default 12, meaning ADC sample width (legal 8..15).
REQ-002 SHALL have parameter AW, default 10, meaning circular sample buffer address bits (depth 2^AW).
REQ-003 SHALL have parameter FAW, default 11, meaning output FIFO address bits (depth 2^FAW words x 16).
REQ-004 SHALL have parameter PBITS, default 16, meaning log2 of pedestal averaging length.
REQ-005 SHALL have ports, as name  direction  width  meaning:
- clk  in  1  sole clock; din arrives synchronous to it.
- rst  in  1  reset, asynchronous, active-high.
- din_vld  in  1  ADC sample strobe.
- din  in  DW  raw ADC sample.
- num  in  6  channel number.
- cped  in  DW  common pedestal.
- zthr / sthr  in  DW  zero-suppression / self-trigger thresholds.
- prescale  in  16  self-trigger prescale.
- winbeg / swinbeg  in  AW  master / self window offset before trigger.
- winlen  in  8  window length, samples.
- trigger  in  16  master trigger; bit15 is the single-cycle strobe, whole word is trigger info.
- tmask / stmask  in  1  master / self trigger masks.
- raw  in  1  test mode.
- ped  out  DW  current pedestal.
- dout  out  16  FIFO head word.
- req  out  1  FIFO non-empty.
- ack  in  1  pop head word.
- fifo_full  out  1  insufficient FIFO space.
- mt_lost  out  16  count of dropped master triggers.

Function
REQ-006 SHALL, on each din_vld, accumulate din; after 2^PBITS samples SHALL load ped = sum >> PBITS and restart the sum with the current sample.
REQ-007 SHALL compute pdata = din - ped + cped, clamped to 0..2^DW-1 (no wrap), or pdata = din when raw=1.
REQ-008 SHALL write pdata into the buffer at waddr on each din_vld, incrementing waddr modulo 2^AW.
REQ-009 SHALL arm the self trigger on the first valid sample with pdata > sthr+cped and disarm until a sample with pdata < sthr+cped; sum computed at DW+1 bits.
REQ-010 SHALL, on each arming event, fire when presc_cnt >= prescale and reset presc_cnt to 0, else increment presc_cnt; a fire is suppressed, without affecting the count, when stmask=1 or raw=1; a fire captures saddr = waddr.
REQ-011 SHALL, on trigger[15]=1 with tmask=0, latch trigger and maddr = waddr into a one-deep pending slot; if the slot is already full, the new trigger is dropped and mt_lost increments, saturating at 16'hFFFF.
REQ-012 SHALL run states IDLE, STCOPY, MTHDR, MTNUM, MTCOPY, with default transitions to IDLE.
REQ-013 IDLE: if fifo_full=0 and master pending -> MTHDR; else if self fire pending -> STCOPY; the master trigger has priority.
REQ-014 STCOPY: write header {2'b10,num,winlen}, then winlen samples from saddr-swinbeg ascending modulo 2^AW, then commit -> IDLE.
REQ-015 A master trigger arriving during STCOPY SHALL abort it: write pointer rolls back to the block start, no partial block is committed, and the master block is processed next.
REQ-016 MTHDR/MTNUM/MTCOPY: write {2'b11,num,winlen}, the latched trigger word, then winlen samples {zero-pad,pdata} from maddr-winbeg; free the pending slot on entry to MTHDR.
REQ-017 At MTCOPY end SHALL commit only if raw=1 or some sample > zthr+cped; otherwise roll back the write pointer (block discarded).
REQ-018 winlen=0 SHALL yield a header-only self block; the master block holds header+trigger and is discarded unless raw=1.
REQ-019 SHALL keep write, committed and read pointers of FAW+1 bits; req = (committed != read); fifo_full = free words < winlen+2.
REQ-020 SHALL present dout as show-ahead: head word valid whenever req=1; ack with req=1 pops, and the next word or req=0 appears on the following cycle; back-to-back acks SHALL be honoured; ack with req=0 SHALL be ignored.
REQ-021 SHALL never let uncommitted words become visible on req/dout.

Reset
REQ-022 rst=1 SHALL asynchronously clear all pointers, waddr, state (IDLE), pending flags, presc_cnt, arm flag, pedestal sum/count, ped, dout, req, fifo_full and mt_lost to 0; buffer/FIFO contents are not cleared.
REQ-023 rst asserted mid-block SHALL discard the block; req=0 on the first cycle after release.

Verification
REQ-024 din=100 constant, PBITS=4 -> ped=100 after 16 samples; cped=50 -> pdata=50; din=20 -> pdata=0 (clamped).
REQ-025 sthr=200, prescale=2, three pulses above threshold -> exactly one self block, on the 3rd pulse, with header 16'h8xxx, len=winlen.
REQ-026 Master trigger 16'h8123, winlen=8, one sample > zthr+cped -> 10 words: {2'b11,num,8}, 16'h8123, 8 samples; all samples below the threshold with raw=0 -> no words, req stays 0.
REQ-027 Master trigger 3 cycles into STCOPY -> self block absent, master block complete; three master triggers during a busy block -> mt_lost=2.
REQ-028 ack held continuously during drain -> every word read once, in order, across the FIFO wrap; fifo_full asserts when free < winlen+2 and blocks new starts.
